// File: rtl/ecc_lookup_arbiter.sv
// Purpose: round-robin arbiter sharing the ECC x/y point-lookup tables between two channels.
// Latency: accept-to-rsp_valid is TBL_LAT+1 cycles; one lookup in flight at a time.
// Backpressure: a pending response holds until its rsp_ready; no new request is accepted meanwhile.
//
// Ports:
//   clk, reset (async, active-low)
//   req0/req1_{valid,data,ready}   lookup requests from the two framer channels
//   rsp0/rsp1_{valid,x,y,ready}    coordinate results back to each channel
//   tbl_init, tbl_addr             load strobe and shared address to both tables
//   tbl_x, tbl_y                   table read data (valid TBL_LAT cycles after address sample)
//   busy                           high whenever the controller is not idle
module ecc_lookup_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int INIT_CYCLES = 2,
    parameter int TBL_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_data,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_x,
    output logic [DATA_W-1:0] rsp0_y,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_x,
    output logic [DATA_W-1:0] rsp1_y,
    input  logic              rsp1_ready,
    output logic              tbl_init,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_x,
    input  logic [DATA_W-1:0] tbl_y,
    output logic              busy
);

    // One counter serves both the init hold and the table-latency wait.
    localparam int CNT_MAX = (INIT_CYCLES > TBL_LAT + 1) ? INIT_CYCLES : TBL_LAT + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             rsp_chan;
    logic             grant0;
    logic             grant1;
    logic             init_done;
    logic             wait_done;
    logic             rsp_hs;

    // Ties go to the channel that was not served last.
    assign grant0    = req0_valid && (!req1_valid || last_grant);
    assign grant1    = req1_valid && (!req0_valid || !last_grant);
    assign init_done = (cnt == CNT_W'(INIT_CYCLES));
    // Counter starts at 0 on the edge after acceptance, so reaching TBL_LAT
    // lands the capture on accept edge + TBL_LAT + 1.
    assign wait_done = (cnt == CNT_W'(TBL_LAT));
    assign rsp_hs    = rsp_chan ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state)
            ST_INIT: begin
                if (init_done) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_done) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_hs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            rsp_chan   <= 1'b0;
            tbl_init   <= 1'b0;
            tbl_addr   <= '0;
            rsp0_valid <= 1'b0;
            rsp0_x     <= '0;
            rsp0_y     <= '0;
            rsp1_valid <= 1'b0;
            rsp1_x     <= '0;
            rsp1_y     <= '0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    if (init_done) begin
                        tbl_init <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        tbl_init <= 1'b1;
                        cnt      <= cnt + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        tbl_addr   <= grant1 ? req1_data : req0_data;
                        rsp_chan   <= grant1;
                        last_grant <= grant1;
                        cnt        <= '0;
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        if (rsp_chan) begin
                            rsp1_valid <= 1'b1;
                            rsp1_x     <= tbl_x;
                            rsp1_y     <= tbl_y;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_x     <= tbl_x;
                            rsp0_y     <= tbl_y;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Data is left in place after the handshake.
                    if (rsp_hs) begin
                        if (rsp_chan) rsp1_valid <= 1'b0;
                        else          rsp0_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
